// File: rtl/bram_fifo_ctrl.sv
// FWFT FIFO controller in front of a simple dual-port, read-first BRAM with 1-cycle read latency.
// Optional sticky overflow/underflow flags when FIFO_ERR_EN is defined.
module bram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_wr_ea,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_douta,
`ifdef FIFO_ERR_EN
  output logic                  err_ovf,
  output logic                  err_udf,
`endif
  output logic [ADDR_WIDTH+1:0] count
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam int unsigned CntW = ADDR_WIDTH + 2;
  localparam logic [PtrW-1:0] RamDepth = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            out_words_q, out_words_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic [PtrW-1:0] ram_count;
  logic [2:0]      occ_after_pop;
  logic            push, pop, fetch;

  assign ram_count = wr_ptr_q - rd_ptr_q;
  assign s_ready   = !rst && (ram_count != RamDepth);
  assign m_valid   = (out_words_q != 2'd0);
  assign m_data    = head_q;
  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;

  // Words that will occupy the output stage next cycle if no new fetch is issued.
  assign occ_after_pop = {1'b0, out_words_q} + {2'b00, inflight_q} - {2'b00, pop};
  // Registered ram_count keeps the read off a word being written this cycle.
  assign fetch = (ram_count != '0) && (occ_after_pop <= 3'd1);

  assign ram_wr_ea   = push;
  assign ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_data_in = s_data;
  assign ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  assign count = CntW'(ram_count) + CntW'(inflight_q) + CntW'(out_words_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = fetch;
    out_words_d = out_words_q;
    head_d      = head_q;
    skid_d      = skid_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (fetch) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (pop) begin
      head_d      = skid_q;
      out_words_d = out_words_q - 2'd1;
    end
    // Returning read lands in the first slot still free after the pop.
    if (inflight_q) begin
      if (out_words_d == 2'd0) head_d = ram_douta;
      else                     skid_d = ram_douta;
      out_words_d = out_words_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      out_words_q <= 2'd0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      out_words_q <= out_words_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
    end
  end

`ifdef FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (s_valid && !s_ready) err_ovf <= 1'b1;
      if (m_ready && !m_valid) err_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a small read-first BRAM model (ADDR_WIDTH=2).
module tb_bram_fifo_ctrl;
  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          ram_wr_ea;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_data_in;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_douta = '0;
  logic [AW+1:0] count;
`ifdef FIFO_ERR_EN
  logic          err_ovf;
  logic          err_udf;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

  // Read-first BRAM: registered read returns the old word on an address collision.
  always @(posedge clk) begin
    if (ram_wr_ea) mem[ram_wr_addr] <= ram_data_in;
    ram_douta <= mem[ram_rd_addr];
  end

  bram_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .ram_wr_ea  (ram_wr_ea),
    .ram_wr_addr(ram_wr_addr),
    .ram_data_in(ram_data_in),
    .ram_rd_addr(ram_rd_addr),
    .ram_douta  (ram_douta),
`ifdef FIFO_ERR_EN
    .err_ovf    (err_ovf),
    .err_udf    (err_udf),
`endif
    .count      (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Pushes until n words are accepted (bounded), with m_ready held low.
  task automatic fill(input logic [DW-1:0] base, input int n);
    int got = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 20 && got < n; i++) begin
      s_data = base + DW'(got);
      #1;
      if (s_ready) got++;
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data: got %h expected 0000", m_data); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_latency();
    do_reset();
    s_valid = 1'b1;
    s_data  = 16'h0001;
    step();
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_n_m_valid: got %b expected 0", m_valid); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_n1_m_valid: got %b expected 0", m_valid); end
    step();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL lat_n2_m_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== 16'h0001) begin errors++; $display("FAIL lat_n2_m_data: got %h expected 0001", m_data); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL lat_count: got %0d expected 1", count); end
  endtask

  task automatic test_fill_drain();
    int acc = 0;
    logic [DW-1:0] exp;
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 16'h0010 + DW'(i);
      #1;
      if (s_ready) acc++;
      step();
    end
    s_valid = 1'b0;
    #1;
    checks++; if (acc != 6) begin errors++; $display("FAIL fill_accepted: got %0d expected 6", acc); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready: got %b expected 0", s_ready); end
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL fill_count: got %0d expected 6", count); end
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp = 16'h0010 + DW'(i);
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp) begin
        errors++; $display("FAIL drain_word%0d: got valid=%b data=%h expected valid=1 data=%h", i, m_valid, m_data, exp);
      end
      step();
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_m_valid: got %b expected 0", m_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    int pushed = 0;
    int popped = 0;
    int first = -1;
    int last = -1;
    logic [DW-1:0] exp;
    logic [AW-1:0] exp_addr;
    do_reset();
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && popped < 20; cyc++) begin
      s_valid = (pushed < 20);
      s_data  = 16'h0100 + DW'(pushed);
      #1;
      if (s_valid && s_ready) begin
        exp_addr = AW'(pushed);
        checks++;
        if (ram_wr_ea !== 1'b1 || ram_wr_addr !== exp_addr) begin
          errors++; $display("FAIL b2b_wr_addr%0d: got ea=%b addr=%0d expected ea=1 addr=%0d", pushed, ram_wr_ea, ram_wr_addr, exp_addr);
        end
        pushed++;
      end
      if (m_valid) begin
        exp = 16'h0100 + DW'(popped);
        checks++;
        if (m_data !== exp) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", popped, m_data, exp); end
        if (first < 0) first = cyc;
        last = cyc;
        popped++;
      end
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    checks++; if (popped != 20) begin errors++; $display("FAIL b2b_popped: got %0d expected 20", popped); end
    checks++; if (last - first != 19) begin errors++; $display("FAIL b2b_gapless: got span %0d expected 19", last - first); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_count: got %0d expected 0", count); end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] exp_q [6] = '{16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h0025, 16'h0055};
    do_reset();
    fill(16'h0020, 6);
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL full_count: got %0d expected 6", count); end
    s_valid = 1'b1;
    s_data  = 16'h0055;
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_pp_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_data !== 16'h0020) begin errors++; $display("FAIL full_pp_head: got %h expected 0020", m_data); end
    step();
    m_ready = 1'b0;
    #1;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL full_pp_count: got %0d expected 5", count); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_next_s_ready: got %b expected 1", s_ready); end
    step();
    s_valid = 1'b0;
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL full_repush_count: got %0d expected 6", count); end
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_q[i]) begin
        errors++; $display("FAIL full_drain%0d: got valid=%b data=%h expected valid=1 data=%h", i, m_valid, m_data, exp_q[i]);
      end
      step();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    int waited = 0;
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 16'h0031 + DW'(i);
      step();
    end
    s_valid = 1'b0;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL midop_count: got %0d expected 3", count); end
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midop_rst_m_valid: got %b expected 0", m_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL midop_rst_count: got %0d expected 0", count); end
    step();
    rst = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h00AA;
    step();
    s_valid = 1'b0;
    while (!m_valid && waited < 6) begin
      step();
      waited++;
    end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL midop_timeout: got m_valid=%b expected 1", m_valid); end
    checks++; if (m_data !== 16'h00AA) begin errors++; $display("FAIL midop_data: got %h expected 00aa", m_data); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL midop_final_count: got %0d expected 1", count); end
  endtask

`ifdef FIFO_ERR_EN
  task automatic test_err_flags();
    do_reset();
    checks++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin errors++; $display("FAIL err_init: got ovf=%b udf=%b expected 0 0", err_ovf, err_udf); end
    fill(16'h0040, 6);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL err_ovf_set: got %b expected 1", err_ovf); end
    step();
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL err_ovf_sticky: got %b expected 1", err_ovf); end
    checks++; if (err_udf !== 1'b0) begin errors++; $display("FAIL err_udf_clear: got %b expected 0", err_udf); end
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++; if (err_udf !== 1'b0) begin errors++; $display("FAIL err_udf_early: got %b expected 0", err_udf); end
    step();
    m_ready = 1'b0;
    checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL err_udf_set: got %b expected 1", err_udf); end
    do_reset();
    checks++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin errors++; $display("FAIL err_rst: got ovf=%b udf=%b expected 0 0", err_ovf, err_udf); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_fill_drain();
    test_back_to_back();
    test_full_push_pop();
    test_reset_midop();
`ifdef FIFO_ERR_EN
    test_err_flags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
